// File: rtl/note_sched_pkg.sv
// Shared sizes, defaults and FSM encoding for the note scheduler.
package note_sched_pkg;
    localparam int NKEYS_DEF    = 8;
    localparam int NOTE_W       = 3;
    localparam int MIN_GATE_DEF = 1000000;
    localparam int GCNT_W       = 26;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_EMIT = 2'd2
    } state_t;
endpackage

// File: rtl/note_sched_prio_enc8.sv
// Lowest-index priority encoder: 8-bit request vector to 3-bit index plus any flag.
module prio_enc8 (
    input  logic [7:0] i_vec,
    output logic [2:0] o_idx,
    output logic       o_any
);
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 3'(i);
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/note_sched.sv
// Keyboard note scheduler: picks the most recent key (or lowest held key), enforces a
// minimum gate time per note and hands on/off events to a tone generator via valid/ready.
module note_sched
    import note_sched_pkg::*;
#(
    parameter int NKEYS    = NKEYS_DEF,
    parameter int MIN_GATE = MIN_GATE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NKEYS-1:0]  key_n,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              evt_on,
    output logic [NOTE_W-1:0] evt_note,
    output logic              gate,
    output logic [NOTE_W-1:0] note_idx
);
    localparam logic [GCNT_W-1:0] W_MG = GCNT_W'(MIN_GATE);

    state_t              r_state, w_state_nxt;
    logic [NKEYS-1:0]    r_key_prev;
    logic [NOTE_W-1:0]   r_last_key;
    logic                r_last_vld;
    logic                r_evt_on;
    logic [NOTE_W-1:0]   r_evt_note;
    logic                r_gate;
    logic [NOTE_W-1:0]   r_note_idx;
    logic [GCNT_W-1:0]   r_gate_cnt;

    logic [7:0]          w_edge8, w_held8, w_keyn8;
    logic [NOTE_W-1:0]   w_edge_idx, w_held_idx, w_des_note, w_nxt_note;
    logic                w_edge_any, w_held_any, w_des_vld;
    logic                w_load, w_nxt_on, w_hs;

    // Unused encoder inputs read as not-pressed so any NKEYS <= 8 works.
    always_comb begin
        w_edge8 = '0;
        w_held8 = '0;
        w_keyn8 = '1;
        for (int i = 0; i < NKEYS; i++) begin
            w_edge8[i] = r_key_prev[i] & ~key_n[i];
            w_held8[i] = ~r_key_prev[i];
            w_keyn8[i] = key_n[i];
        end
    end

    prio_enc8 u_enc_edge (.i_vec(w_edge8), .o_idx(w_edge_idx), .o_any(w_edge_any));
    prio_enc8 u_enc_held (.i_vec(w_held8), .o_idx(w_held_idx), .o_any(w_held_any));

    // Desired note uses registered key state only, giving the one-cycle press latency.
    assign w_des_vld  = r_last_vld | w_held_any;
    assign w_des_note = r_last_vld ? r_last_key : w_held_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_nxt_on    = r_evt_on;
        w_nxt_note  = r_evt_note;
        w_hs        = 1'b0;
        evt_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_des_vld) begin
                    w_state_nxt = S_EMIT;
                    w_load      = 1'b1;
                    w_nxt_on    = 1'b1;
                    w_nxt_note  = w_des_note;
                end
            end
            S_PLAY: begin
                if (r_gate_cnt >= W_MG) begin
                    if (!w_des_vld) begin
                        w_state_nxt = S_EMIT;
                        w_load      = 1'b1;
                        w_nxt_on    = 1'b0;
                        w_nxt_note  = r_note_idx;
                    end else if (w_des_note != r_note_idx) begin
                        w_state_nxt = S_EMIT;
                        w_load      = 1'b1;
                        w_nxt_on    = 1'b1;
                        w_nxt_note  = w_des_note;
                    end
                end
            end
            S_EMIT: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = r_evt_on ? S_PLAY : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_key_prev <= '1;
            r_last_key <= '0;
            r_last_vld <= 1'b0;
            r_evt_on   <= 1'b0;
            r_evt_note <= '0;
            r_gate     <= 1'b0;
            r_note_idx <= '0;
            r_gate_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_key_prev <= key_n;
            if (w_edge_any) begin
                r_last_key <= w_edge_idx;
                r_last_vld <= 1'b1;
            end else if (r_last_vld && w_keyn8[r_last_key]) begin
                r_last_vld <= 1'b0;
            end
            if (w_load) begin
                r_evt_on   <= w_nxt_on;
                r_evt_note <= w_nxt_note;
            end
            if (w_hs) begin
                r_gate     <= r_evt_on;
                r_gate_cnt <= '0;
                if (r_evt_on) r_note_idx <= r_evt_note;
            end else if (r_state == S_PLAY && r_gate_cnt < W_MG) begin
                r_gate_cnt <= r_gate_cnt + 1'b1;
            end
        end
    end

    assign evt_on   = r_evt_on;
    assign evt_note = r_evt_note;
    assign gate     = r_gate;
    assign note_idx = r_note_idx;
endmodule

// File: tb/tb_note_sched.sv
// Bench for note_sched: directed scenarios plus random key/ready traffic against a behavioural model.
module tb_note_sched;
    localparam int MG = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       evt_ready = 1'b1;
    logic [7:0] key_n = '1;
    logic       evt_valid, evt_on, gate;
    logic [2:0] evt_note, note_idx;

    int total = 0;
    int bad   = 0;
    int ev_cnt = 0, ev_on = 0, ev_note = 0;

    // Model: mode 0 = silent, 1 = sounding, 2 = event offered.
    logic [7:0] m_prev = '1;
    int m_last = 0, m_lvld = 0, m_mode = 0, m_on = 0, m_note = 0;
    int m_gate = 0, m_idx = 0, m_cnt = 0;

    always #5 clk = ~clk;

    note_sched #(.NKEYS(8), .MIN_GATE(MG)) dut (
        .clk(clk), .rst(rst), .key_n(key_n),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_on(evt_on), .evt_note(evt_note),
        .gate(gate), .note_idx(note_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_low(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (!v[i]) return i;
        return -1;
    endfunction

    function automatic int first_fall(input logic [7:0] prev, input logic [7:0] cur);
        for (int i = 0; i < 8; i++) if (prev[i] && !cur[i]) return i;
        return -1;
    endfunction

    task automatic model_tick();
        int des, pe;
        if (rst) begin
            m_prev = '1; m_last = 0; m_lvld = 0; m_mode = 0;
            m_on = 0; m_note = 0; m_gate = 0; m_idx = 0; m_cnt = 0;
            return;
        end
        des = m_lvld ? m_last : first_low(m_prev);
        if (m_mode == 0) begin
            if (des >= 0) begin m_mode = 2; m_on = 1; m_note = des; end
        end else if (m_mode == 1) begin
            if (m_cnt < MG) m_cnt++;
            else if (des < 0) begin m_mode = 2; m_on = 0; m_note = m_idx; end
            else if (des != m_idx) begin m_mode = 2; m_on = 1; m_note = des; end
        end else if (evt_ready) begin
            m_gate = m_on;
            if (m_on != 0) m_idx = m_note;
            m_cnt  = 0;
            m_mode = (m_on != 0) ? 1 : 0;
        end
        pe = first_fall(m_prev, key_n);
        if (pe >= 0) begin m_last = pe; m_lvld = 1; end
        else if (m_lvld != 0 && key_n[m_last]) m_lvld = 0;
        m_prev = key_n;
    endtask

    task automatic step();
        if (evt_valid && evt_ready) begin
            ev_cnt++; ev_on = int'(evt_on); ev_note = int'(evt_note);
        end
        @(posedge clk);
        model_tick();
        #1;
        chk("evt_valid", evt_valid, m_mode == 2);
        chk("gate", gate, m_gate[0]);
        chk("note_idx", note_idx, m_idx[2:0]);
        if (m_mode == 2 || rst) begin
            chk("evt_on", evt_on, m_on[0]);
            chk("evt_note", evt_note, m_note[2:0]);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input int lim);
        for (int i = 0; i < lim && !evt_valid; i++) step();
        chk("wait_valid", evt_valid, 1'b1);
    endtask

    logic hold_on;
    logic [2:0] hold_note;

    initial begin
        // Reset state
        steps(3);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_on", evt_on, 1'b0);
        chk("rst_gate", gate, 1'b0);
        chk("rst_idx", note_idx, 3'd0);
        rst = 1'b0;
        steps(2);

        // Single press latency and acceptance
        key_n[3] = 1'b0;
        step();
        chk("p3_e0_valid", evt_valid, 1'b0);
        step();
        chk("p3_e1_valid", evt_valid, 1'b1);
        chk("p3_e1_on", evt_on, 1'b1);
        chk("p3_e1_note", evt_note, 3'd3);
        step();
        chk("p3_gate", gate, 1'b1);
        chk("p3_idx", note_idx, 3'd3);

        // Switch request inside minimum gate waits, then one legato event
        steps(3);
        ev_cnt = 0;
        key_n[5] = 1'b0;
        steps(20);
        chk("sw_events", ev_cnt, 1);
        chk("sw_on", ev_on, 1);
        chk("sw_note", ev_note, 5);
        key_n = '1;
        steps(25);
        chk("rel_gate", gate, 1'b0);

        // Simultaneous press picks lowest; release falls back to remaining key
        key_n[2] = 1'b0; key_n[6] = 1'b0;
        steps(5);
        chk("dual_idx", note_idx, 3'd2);
        steps(20);
        key_n[2] = 1'b1;
        steps(20);
        chk("fall_idx", note_idx, 3'd6);
        chk("fall_gate", gate, 1'b1);
        key_n[6] = 1'b1;
        steps(22);
        chk("off_gate", gate, 1'b0);

        // Stalled event is frozen while keys move
        evt_ready = 1'b0;
        key_n[4] = 1'b0;
        wait_valid(10);
        hold_on = evt_on; hold_note = evt_note;
        for (int i = 0; i < 10; i++) begin
            key_n = 8'($urandom);
            step();
            chk("stall_valid", evt_valid, 1'b1);
            chk("stall_on", evt_on, hold_on);
            chk("stall_note", evt_note, hold_note);
        end
        evt_ready = 1'b1;
        key_n = '1;
        steps(60);

        // Reset while an event is pending drops it; held key re-triggers
        evt_ready = 1'b0;
        key_n[1] = 1'b0;
        wait_valid(10);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_emit_valid", evt_valid, 1'b0);
            chk("rst_emit_on", evt_on, 1'b0);
            chk("rst_emit_note", evt_note, 3'd0);
            chk("rst_emit_gate", gate, 1'b0);
            chk("rst_emit_idx", note_idx, 3'd0);
        end
        rst = 1'b0;
        evt_ready = 1'b1;
        step();
        chk("rr_e0_valid", evt_valid, 1'b0);
        step();
        chk("rr_e1_valid", evt_valid, 1'b1);
        chk("rr_e1_on", evt_on, 1'b1);
        chk("rr_e1_note", evt_note, 3'd1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int k;
            evt_ready = ($urandom_range(3) != 0);
            if ($urandom_range(5) == 0) begin
                k = $urandom_range(7);
                key_n[k] = ~key_n[k];
            end
            rst = ($urandom_range(499) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/note_sched.md
NOTE_SCHED -- requirements
Module: note_sched

Interface
REQ-001 Parameter NKEYS, default 8: number of debounced keys; note index width is 3 bits.
REQ-002 Parameter MIN_GATE, default 1000000: minimum cycles a started note sounds before any change (20 ms at 50 MHz).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 key_n  in  NKEYS  debounced key levels from per-key debouncers; 0 = pressed, 1 = released.
REQ-006 evt_valid  out  1  note event pending to tone generator.
REQ-007 evt_ready  in  1  tone generator accepts the event this cycle.
REQ-008 evt_on  out  1  1 = start/switch to evt_note; 0 = silence.
REQ-009 evt_note  out  3  note index carried by the event.
REQ-010 gate  out  1  1 while a note is sounding (last accepted event was on).
REQ-011 note_idx  out  3  index of the sounding note, per the last accepted on-event.

Function
REQ-012 The block SHALL register key_n into key_prev each cycle; press edge on key i = key_prev[i]=1 and key_n[i]=0.
REQ-013 On any press edge, last_key SHALL load the lowest-index key with a press edge that cycle and last_vld SHALL be set to 1.
REQ-014 last_vld SHALL clear when key_n[last_key]=1 (release) and no press edge occurs that cycle; a press edge in the same cycle wins.
REQ-015 desired note = last_key if last_vld, else lowest-index key with key_n=0; desired is none if no key is held.
REQ-016 FSM states: IDLE, PLAY, EMIT; exactly one active.
REQ-017 IDLE: if desired exists -> EMIT with evt_on=1, evt_note=desired; else stay.
REQ-018 PLAY: gate_cnt (26-bit) increments, saturating at MIN_GATE; no decision is taken while gate_cnt < MIN_GATE.
REQ-019 PLAY with gate_cnt = MIN_GATE: desired none -> EMIT off; desired != note_idx -> EMIT on with desired; else stay.
REQ-020 EMIT: evt_valid=1; evt_on/evt_note SHALL hold stable until the cycle evt_valid and evt_ready are both 1.
REQ-021 On handshake: gate<=evt_on, note_idx<=evt_note if evt_on (else unchanged), gate_cnt<=0; next state PLAY if evt_on else IDLE.
REQ-022 Key activity during EMIT SHALL NOT alter the pending event; it is re-evaluated in PLAY/IDLE afterwards.
REQ-023 A note switch SHALL be one on-event (legato); no intervening off-event.
REQ-024 Latency: key pressed in IDLE, first sampled low at edge E0 -> evt_valid high after edge E1.
REQ-025 evt_valid SHALL be 0 outside EMIT; evt_ready is ignored when evt_valid=0.
REQ-026 Keys held through reset SHALL appear as press edges in the first cycle after reset.

Reset
REQ-027 While rst=1: state IDLE, evt_valid=0, evt_on=0, evt_note=0, gate=0, note_idx=0, gate_cnt=0, last_vld=0, last_key=0, key_prev all ones.
REQ-028 Reset asserted in EMIT SHALL drop the pending event without handshake.

Structure
REQ-029 Shared package SHALL hold NKEYS, note width (3), MIN_GATE default, gate counter width (26), and the FSM state enum.
REQ-030 Lowest-index selection SHALL be one sub-module, prio_enc8 (8-bit vector -> 3-bit index + any flag), instantiated twice (press edges, held keys).

Verification (MIN_GATE=16 in bench)
REQ-031 Press key 3 in IDLE, evt_ready=1 -> evt_valid high after E1 with on=1, note=3; gate=1, note_idx=3 next cycle.
REQ-032 Key 3 sounding, press key 5 at cycle 4 after start -> no event until gate_cnt=16, then single on-event note=5.
REQ-033 Press keys 2 and 6 same cycle -> on-event note=2; release 2 after min gate -> on-event note=6; release 6 -> off-event, gate=0.
REQ-034 evt_ready held 0 for 10 cycles in EMIT while keys toggle -> evt_valid, evt_on, evt_note unchanged for all 10 cycles.
REQ-035 Assert rst during EMIT with key 1 held -> all outputs 0 during reset; after release, fresh on-event note=1.
